// File: rtl/div5_pkg.sv
// ---------------------------------------------------------------------------
// div5_pkg
// Shared types and helpers for the nibble-serial divisible-by-five scheduler.
//   state_t        : scheduler FSM states (IDLE, ACCUM, DONE)
//   NIBBLE_W       : width of one serial digit processed per cycle
//   mod15_to_mod5  : maps an end-around-carry mod-15 accumulator to mod 5
// ---------------------------------------------------------------------------
package div5_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int NIBBLE_W = 4;

    // Because 5 divides 15, the word's residue mod 5 is the mod-15 residue
    // reduced once more. The accumulator may hold 15, which is the second
    // encoding of zero; 15 % 5 already gives 0, so no special case is needed.
    function automatic logic [2:0] mod15_to_mod5(input logic [3:0] acc);
        logic [3:0] r;
        r = acc % 4'd5;
        return r[2:0];
    endfunction

endpackage

// File: rtl/div5_nibble_accum.sv
// ---------------------------------------------------------------------------
// div5_nibble_accum
// Serial mod-15 reducer: folds a word into a 4-bit end-around-carry
// accumulator one nibble per step, least-significant nibble first.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   load     : capture data, clear accumulator and nibble counter
//   data     : word to reduce (BIT_WIDTH bits)
//   step     : consume the current low nibble
//   last     : the nibble being consumed this cycle is the final one
//   acc      : accumulator value including the current nibble, i.e. the
//              value the register takes on the next step
// ---------------------------------------------------------------------------
module div5_nibble_accum
    import div5_pkg::*;
#(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [BIT_WIDTH-1:0] data,
    input  logic                 step,
    output logic                 last,
    output logic [NIBBLE_W-1:0]  acc
);

    localparam int NIB   = BIT_WIDTH / NIBBLE_W;
    localparam int CNT_W = $clog2(NIB);

    logic [BIT_WIDTH-1:0] shreg;
    logic [NIBBLE_W-1:0]  acc_q;
    logic [CNT_W-1:0]     cnt;
    logic [NIBBLE_W:0]    sum;

    // 16 == 1 (mod 15), so a carry out of the 4-bit sum is wrapped back in
    // as +1. The result never overflows again: max is 15+15 -> 14+1 = 15.
    // Exposing the folded value (rather than acc_q) lets the scheduler
    // capture the final residue on the same edge the last nibble is used.
    always_comb begin
        sum = {1'b0, acc_q} + {1'b0, shreg[NIBBLE_W-1:0]};
        acc = sum[NIBBLE_W] ? sum[NIBBLE_W-1:0] + NIBBLE_W'(1)
                            : sum[NIBBLE_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg <= '0;
            acc_q <= '0;
            cnt   <= '0;
        end else if (load) begin
            shreg <= data;
            acc_q <= '0;
            cnt   <= '0;
        end else if (step) begin
            acc_q <= acc;
            shreg <= shreg >> NIBBLE_W;
            cnt   <= cnt + CNT_W'(1);
        end
    end

    assign last = (cnt == CNT_W'(NIB - 1));

endmodule

// File: rtl/div5_scheduler.sv
// ---------------------------------------------------------------------------
// div5_scheduler
// Shares one nibble-serial divisible-by-five datapath between NUM_REQ
// requesters. A round-robin arbiter picks one requester per job, the word is
// reduced mod 15 one nibble per cycle, and the mod-5 result is returned on a
// valid/ready response port tagged with the requester index.
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   req_valid/ready : per-requester handshake (at most one ready bit high)
//   req_data        : packed words, requester i at [i*BIT_WIDTH +: BIT_WIDTH]
//   resp_valid/ready: result handshake
//   resp_id         : requester that owns the result
//   resp_divisible  : word is divisible by 5
//   resp_residue    : word mod 5
//   busy            : a job is in flight (state is not IDLE)
//   done_count      : completed responses, wraps modulo 2^16
// ---------------------------------------------------------------------------
module div5_scheduler
    import div5_pkg::*;
#(
    parameter int BIT_WIDTH = 32,
    parameter int NUM_REQ   = 4,
    parameter int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BIT_WIDTH-1:0] req_data,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [ID_W-1:0]              resp_id,
    output logic                         resp_divisible,
    output logic [2:0]                   resp_residue,
    output logic                         busy,
    output logic [15:0]                  done_count
);

    if ((BIT_WIDTH % NIBBLE_W) != 0 || BIT_WIDTH < 8) begin : g_bad_width
        $error("div5_scheduler: BIT_WIDTH must be a multiple of 4 and >= 8");
    end
    if (NUM_REQ < 2) begin : g_bad_num_req
        $error("div5_scheduler: NUM_REQ must be at least 2");
    end

    state_t               state;
    state_t               state_next;
    logic [ID_W-1:0]      rr_ptr;
    logic [ID_W-1:0]      grant;
    logic [ID_W-1:0]      rr_next;
    logic                 found;
    int                   idx;
    logic                 any_valid;
    logic                 handshake;
    logic                 accum_last;
    logic [NIBBLE_W-1:0]  acc_fold;
    logic [BIT_WIDTH-1:0] grant_data;
    logic [2:0]           final_residue;
    logic [15:0]          done_cnt;

    assign any_valid = |req_valid;

    // Round-robin search starting at rr_ptr; the first valid index found
    // wins. When nothing is valid the grant value is unused.
    always_comb begin
        grant = rr_ptr;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(rr_ptr) + i) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                grant = idx[ID_W-1:0];
                found = 1'b1;
            end
        end
    end

    assign rr_next = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);

    always_comb begin
        req_ready = '0;
        if (state == IDLE && any_valid && !rst) begin
            req_ready[grant] = 1'b1;
        end
    end

    assign handshake  = |(req_valid & req_ready);
    assign grant_data = req_data[int'(grant)*BIT_WIDTH +: BIT_WIDTH];

    div5_nibble_accum #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_accum (
        .clk  (clk),
        .rst  (rst),
        .load (handshake),
        .data (grant_data),
        .step (state == ACCUM),
        .last (accum_last),
        .acc  (acc_fold)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (handshake) state_next = ACCUM;
            ACCUM:   if (accum_last) state_next = DONE;
            DONE:    if (resp_valid && resp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign final_residue = mod15_to_mod5(acc_fold);

    // The response is captured on the edge that consumes the last nibble,
    // so resp_valid is already high in the first DONE cycle and a
    // zero-wait consumer returns the block to IDLE one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            rr_ptr         <= '0;
            resp_valid     <= 1'b0;
            resp_id        <= '0;
            resp_divisible <= 1'b0;
            resp_residue   <= '0;
            done_cnt       <= '0;
        end else begin
            state <= state_next;
            if (handshake) begin
                resp_id <= grant;
                rr_ptr  <= rr_next;
            end
            if (state == ACCUM && accum_last) begin
                resp_residue   <= final_residue;
                resp_divisible <= (final_residue == 3'd0);
                resp_valid     <= 1'b1;
            end
            if (state == DONE && resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
                done_cnt   <= done_cnt + 16'd1;
            end
        end
    end

    assign busy       = (state != IDLE);
    assign done_count = done_cnt;

endmodule
